dmem_sized: RTL and testbench

Parametrised byte-addressed data memory for the MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Requests use a valid/ready handshake and read data is registered with a one-cycle latency. Misaligned and out-of-range accesses are detected and reported instead of corrupting memory.

---
 rtl/dmem_sized_if.sv | 26 ++
 rtl/dmem_sized.sv | 152 +++++++++++++++
 tb/tb_dmem_sized.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sized_if.sv
// Request/response bundle for the MEM-stage data memory.
// The master issues load/store requests; the slave returns registered read data and error pulses.
interface dmem_sized_if #(
   parameter int ADDR_W = 32
);
   logic              req_i;
   logic              ready_o;
   logic              we_i;
   logic [1:0]        size_i;
   logic              unsigned_i;
   logic [ADDR_W-1:0] addr_i;
   logic [31:0]       wdata_i;
   logic [31:0]       rdata_o;
   logic              rvalid_o;
   logic              err_o;

   modport master (
      output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
      input  ready_o, rdata_o, rvalid_o, err_o
   );

   modport slave (
      input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
      output ready_o, rdata_o, rvalid_o, err_o
   );
endinterface

// File: rtl/dmem_sized.sv
// Byte-addressed data memory with byte/half/word access, registered loads and error reporting.
// Optional DMEM_CLEAR_EN: zero the whole array after reset before accepting requests.
module dmem_sized #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   dmem_sized_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [31:0]      r_rdata;
   logic             r_rvalid;
   logic             r_err;

   logic             w_ready;
   logic             w_acc;
   logic             w_misal;
   logic             w_oor;
   logic             w_bad;
   logic             w_we;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_lane;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;

   function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicating the narrow datum puts it on every lane; the byte enables pick the right one.
   function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   assign w_idx   = bus.addr_i[IDX_W+1:2];
   assign w_lane  = bus.addr_i[1:0];
   // DEPTH is a power of two, so any set bit above the index field means out of range.
   assign w_oor   = |bus.addr_i[ADDR_W-1:IDX_W+2];
   assign w_bad   = w_misal | w_oor;
   assign w_acc   = bus.req_i & w_ready;
   assign w_we    = w_acc & bus.we_i & ~w_bad;
   assign w_be    = f_byte_en(bus.size_i, w_lane);
   assign w_wdata = f_store_data(bus.size_i, bus.wdata_i);

   always_comb begin
      w_misal = 1'b0;
      case (bus.size_i)
         2'b00:   w_misal = 1'b0;
         2'b01:   w_misal = w_lane[0];
         2'b10:   w_misal = |w_lane;
         default: w_misal = 1'b1;
      endcase
   end

`ifdef DMEM_CLEAR_EN
   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_clr_cnt;
   logic [IDX_W-1:0] w_clr_cnt_nxt;
   logic             w_clr_we;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_ready       = 1'b0;
      w_clr_we      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_clr_we      = 1'b1;
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == '1) w_state_nxt = S_RUN;
         end
         S_RUN: w_ready = 1'b1;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_we) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
   end
`else
   assign w_ready = 1'b1;

   always_ff @(posedge clk_i) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
   end
`endif

   // Response stage: the array read sees any store accepted on the previous edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_acc & ~bus.we_i;
         r_err    <= w_acc & w_bad;
         if (w_acc && !bus.we_i)
            r_rdata <= w_bad ? 32'h0 : f_load(r_mem[w_idx], w_lane, bus.size_i, bus.unsigned_i);
      end
   end

   assign bus.ready_o  = w_ready;
   assign bus.rdata_o  = r_rdata;
   assign bus.rvalid_o = r_rvalid;
   assign bus.err_o    = r_err;
endmodule

// File: tb/tb_dmem_sized.sv
// Directed and randomized checks of dmem_sized: extension, lane placement, errors, reset, throughput.
// Define DMEM_CLEAR_EN to build against the clearing variant (DEPTH 16).
module tb_dmem_sized;
`ifdef DMEM_CLEAR_EN
   localparam int TB_DEPTH = 16;
   localparam bit CLR      = 1'b1;
`else
   localparam int TB_DEPTH = 256;
   localparam bit CLR      = 1'b0;
`endif
   localparam logic [31:0] OOR_ADDR = 32'(TB_DEPTH * 4);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   dmem_sized_if #(.ADDR_W(32)) bus ();

   dmem_sized #(.DEPTH(TB_DEPTH), .ADDR_W(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      bus.req_i      = 1'b1;
      bus.we_i       = we;
      bus.size_i     = sz;
      bus.unsigned_i = uns;
      bus.addr_i     = addr;
      bus.wdata_i    = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.req_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 4 * TB_DEPTH + 8; c++) begin
         if (bus.ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] w, input int lane, input int sz, input bit uns);
      logic [31:0] v;
      v = w >> (8 * lane);
      if (sz == 0) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic test_reset();
      bit ok;
      #2;
      n_tests++; if (bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid_o); end
      n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err_o); end
      n_tests++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
      n_tests++; if (bus.ready_o !== !CLR) begin n_fail++; $display("FAIL reset_ready got %b want %b", bus.ready_o, !CLR); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL reset_wait_ready got timeout want ready"); end
   endtask

   task automatic test_word();
      drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      n_tests++; if (bus.err_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL word_st err/rvalid got %b/%b want 0/0", bus.err_o, bus.rvalid_o); end
      drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      n_tests++; if (bus.rvalid_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL word_ld rvalid/err got %b/%b want 1/0", bus.rvalid_o, bus.err_o); end
      n_tests++; if (bus.rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_ld rdata got %h want deadbeef", bus.rdata_o); end
   endtask

   task automatic test_subword();
      logic [31:0] a_t [7];
      logic [1:0]  s_t [7];
      logic        u_t [7];
      logic [31:0] e_t [7];
      a_t = '{32'h11, 32'h11, 32'h10, 32'h10, 32'h12, 32'h13, 32'h10};
      s_t = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
      u_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      e_t = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'hFFFF80EF, 32'h0000DEAD, 32'h000000DE, 32'hFFFFFFEF};
      drive(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF80);
      n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL byte_st err got %b want 0", bus.err_o); end
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, s_t[i], u_t[i], a_t[i], 32'h0);
         n_tests++;
         if (bus.rdata_o !== e_t[i] || bus.rvalid_o !== 1'b1 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL subword_ld[%0d] got %h v%b e%b want %h v1 e0", i, bus.rdata_o, bus.rvalid_o, bus.err_o, e_t[i]);
         end
      end
   endtask

   task automatic test_errors();
      drive(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mis_half_st err/rvalid got %b/%b want 1/0", bus.err_o, bus.rvalid_o); end
      drive(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL mis_word_ld got e%b v%b %h want e1 v1 0", bus.err_o, bus.rvalid_o, bus.rdata_o); end
      drive(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rsvd_st err/rvalid got %b/%b want 1/0", bus.err_o, bus.rvalid_o); end
      drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rsvd_ld got e%b %h want e1 0", bus.err_o, bus.rdata_o); end
      drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      n_tests++; if (bus.err_o !== 1'b0 || bus.rdata_o !== 32'hDEAD80EF) begin n_fail++; $display("FAIL unchanged_ld got e%b %h want e0 dead80ef", bus.err_o, bus.rdata_o); end
   endtask

   task automatic test_range();
      drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111);
      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      n_tests++; if (bus.rdata_o !== 32'h11111111) begin n_fail++; $display("FAIL w0_ld got %h want 11111111", bus.rdata_o); end
      drive(1'b0, 2'b10, 1'b0, OOR_ADDR, 32'h0);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL oor_ld got e%b v%b %h want e1 v1 0", bus.err_o, bus.rvalid_o, bus.rdata_o); end
      drive(1'b1, 2'b10, 1'b0, OOR_ADDR, 32'hCAFEF00D);
      n_tests++; if (bus.err_o !== 1'b1 || bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL oor_st err/rvalid got %b/%b want 1/0", bus.err_o, bus.rvalid_o); end
      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      n_tests++; if (bus.rdata_o !== 32'h11111111 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL alias_ld got e%b %h want e0 11111111", bus.err_o, bus.rdata_o); end
      idle();
      n_tests++; if (bus.rvalid_o !== 1'b0 || bus.err_o !== 1'b0 || bus.rdata_o !== 32'h11111111) begin n_fail++; $display("FAIL hold got v%b e%b %h want v0 e0 11111111", bus.rvalid_o, bus.err_o, bus.rdata_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] mdl [TB_DEPTH];
      int          written [$];
      int          idx, j, sz, lane;
      bit          uns;
      logic [31:0] data, exp;
      for (int i = 0; i < 64; i++) begin
         idx  = $urandom_range(0, TB_DEPTH - 1);
         data = $urandom;
         drive(1'b1, 2'b10, 1'b0, 32'(idx * 4), data);
         mdl[idx] = data;
         written.push_back(idx);
         n_tests++; if (bus.ready_o !== 1'b1 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_st[%0d] ready/err got %b/%b want 1/0", i, bus.ready_o, bus.err_o); end
         j    = written[$urandom_range(0, written.size() - 1)];
         sz   = $urandom_range(0, 2);
         lane = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
         uns  = 1'($urandom_range(0, 1));
         exp  = exp_load(mdl[j], lane, sz, uns);
         drive(1'b0, 2'(sz), uns, 32'(j * 4 + lane), 32'h0);
         n_tests++;
         if (bus.rdata_o !== exp || bus.rvalid_o !== 1'b1 || bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ld[%0d] w%0d sz%0d l%0d u%0d got %h v%b r%b want %h", i, j, sz, lane, uns, bus.rdata_o, bus.rvalid_o, bus.ready_o, exp);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      bit ok;
      drive(1'b1, 2'b10, 1'b0, 32'h4, 32'h55AA55AA);
      drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
      n_tests++; if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h55AA55AA) begin n_fail++; $display("FAIL pre_rst_ld got v%b %h want v1 55aa55aa", bus.rvalid_o, bus.rdata_o); end
      #1 rst_n = 1'b0;
      bus.req_i = 1'b0;
      #1;
      n_tests++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 32'h0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst got v%b e%b %h want v0 e0 0", bus.rvalid_o, bus.err_o, bus.rdata_o); end
      n_tests++; if (bus.ready_o !== !CLR) begin n_fail++; $display("FAIL mid_rst_ready got %b want %b", bus.ready_o, !CLR); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_rst_wait got timeout want ready"); end
      idle();
      n_tests++; if (bus.rvalid_o !== 1'b0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got v%b e%b want v0 e0", bus.rvalid_o, bus.err_o); end
   endtask

`ifdef DMEM_CLEAR_EN
   task automatic test_clear();
      @(negedge clk);
      bus.req_i = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         n_tests++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL clr_early[%0d] ready got %b want 0", k, bus.ready_o); end
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= TB_DEPTH; k++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (bus.ready_o !== (k == TB_DEPTH)) begin
            n_fail++;
            $display("FAIL clr_cycle[%0d] ready got %b want %b", k, bus.ready_o, (k == TB_DEPTH));
         end
      end
      for (int w = 0; w < TB_DEPTH; w++) begin
         drive(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0);
         n_tests++; if (bus.rdata_o !== 32'h0 || bus.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL clr_word[%0d] got %h v%b want 0 v1", w, bus.rdata_o, bus.rvalid_o); end
      end
      idle();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_i      = 1'b0;
      bus.we_i       = 1'b0;
      bus.size_i     = 2'b00;
      bus.unsigned_i = 1'b0;
      bus.addr_i     = 32'h0;
      bus.wdata_i    = 32'h0;
      test_reset();
      test_word();
      test_subword();
      test_errors();
      test_range();
      test_back_to_back();
      test_reset_mid();
`ifdef DMEM_CLEAR_EN
      test_clear();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
